// File: rtl/forwarder.sv
// forwarder
//   Moves one element from a granted source queue to a downstream
//   valid/ready port, then returns a one-cycle completion pulse to the
//   scheduler.  Keeps statistics on delivered elements and on grants
//   that found their queue empty.
//
// Ports
//   clock, reset      : single clock, asynchronous active-low reset
//   enable, id        : one-cycle grant and granted queue index
//   empty, lastElem   : per-queue status flags
//   queue_data        : per-queue head element (first-word-fall-through)
//   pop               : one-hot dequeue strobe, only in POP
//   m_data, m_last,
//   m_valid, m_ready  : downstream element port
//   consumed          : completion pulse (DONE state)
//   busy              : any state other than IDLE
//   overrun           : sticky, a grant arrived while busy
//   forwarded_count   : elements accepted downstream (wraps)
//   dropped_count     : grants that hit an empty queue (wraps)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a grant
// POP   | dequeue head of id_q (or drop if empty), capture element
// SEND  | m_valid high, element held until m_ready
// DONE  | consumed pulse, back to IDLE

module forwarder #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_WIDTH       = 64,
  parameter int REGISTER_SIZE    = 32,
  localparam int ID_WIDTH = (NUMBER_OF_QUEUES > 1) ? $clog2(NUMBER_OF_QUEUES) : 1
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        enable,
  input  logic [ID_WIDTH-1:0]                         id,
  input  logic [NUMBER_OF_QUEUES-1:0]                 empty,
  input  logic [NUMBER_OF_QUEUES-1:0]                 lastElem,
  input  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0] queue_data,
  output logic [NUMBER_OF_QUEUES-1:0]                 pop,
  output logic [DATA_WIDTH-1:0]                       m_data,
  output logic                                        m_last,
  output logic                                        m_valid,
  input  logic                                        m_ready,
  output logic                                        consumed,
  output logic                                        busy,
  output logic                                        overrun,
  output logic [REGISTER_SIZE-1:0]                    forwarded_count,
  output logic [REGISTER_SIZE-1:0]                    dropped_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] id_q;

  // pop is decoded from the registered state so it can react to the
  // empty flag seen during the POP cycle itself; it is never high
  // outside POP and at most one bit is set.
  always_comb begin
    pop = '0;
    if (state == POP && !empty[id_q]) begin
      pop[id_q] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      id_q            <= '0;
      m_data          <= '0;
      m_last          <= 1'b0;
      m_valid         <= 1'b0;
      consumed        <= 1'b0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
      forwarded_count <= '0;
      dropped_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            id_q  <= id;
            busy  <= 1'b1;
            state <= POP;
          end
        end

        POP: begin
          if (!empty[id_q]) begin
            m_data  <= queue_data[id_q];
            m_last  <= lastElem[id_q];
            m_valid <= 1'b1;
            state   <= SEND;
          end else begin
            dropped_count <= dropped_count + REGISTER_SIZE'(1);
            consumed      <= 1'b1;
            state         <= DONE;
          end
        end

        SEND: begin
          if (m_ready) begin
            forwarded_count <= forwarded_count + REGISTER_SIZE'(1);
            m_valid         <= 1'b0;
            consumed        <= 1'b1;
            state           <= DONE;
          end
        end

        DONE: begin
          consumed <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          m_valid  <= 1'b0;
          consumed <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase

      // A grant while busy is dropped on the floor; flag it until reset.
      if (enable && state != IDLE) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_forwarder.sv
module tb_forwarder;

  logic             clock;
  logic             reset;
  logic             enable;
  logic [1:0]       id;
  logic [3:0]       empty;
  logic [3:0]       lastElem;
  logic [3:0][63:0] queue_data;
  logic [3:0]       pop;
  logic [63:0]      m_data;
  logic             m_last;
  logic             m_valid;
  logic             m_ready;
  logic             consumed;
  logic             busy;
  logic             overrun;
  logic [31:0]      forwarded_count;
  logic [31:0]      dropped_count;

  int checks = 0;
  int errors = 0;

  int exp_fwd  = 0;
  int exp_drop = 0;
  bit exp_ovr  = 0;

  forwarder dut (
    .clock(clock), .reset(reset), .enable(enable), .id(id),
    .empty(empty), .lastElem(lastElem), .queue_data(queue_data),
    .pop(pop), .m_data(m_data), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .consumed(consumed), .busy(busy), .overrun(overrun),
    .forwarded_count(forwarded_count), .dropped_count(dropped_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  pop_seen;
    logic [3:0]  pop_stray;
    logic [63:0] data;
    logic        last;
    int          valid_cycles;
    int          consumed_cycle;
    int          pulses;
    bit          unstable;
    bit          finished;
  } res_t;

  typedef struct packed {
    logic [1:0]  gid;
    logic [3:0]  emp;
    logic [3:0]  lst;
    logic [63:0] dat;
    int          rdelay;
    logic [3:0]  exp_pop;
    int          exp_valid;
    logic        exp_last;
    int          exp_cons;
    int          exp_fwd;
    int          exp_drop;
  } vec_t;

  // Issue one grant from IDLE and observe the whole transfer.  Cycle 1 is
  // the cycle after the grant edge.  m_ready is held low for rdelay valid
  // cycles, and is high whenever m_valid is low (which must be harmless).
  task automatic do_grant(input logic [1:0] gid, input logic [3:0] emp,
                          input logic [3:0] lst, input logic [63:0] dat,
                          input int rdelay, output res_t r);
    int  vcnt;
    bit  first;
    r = '0;
    r.consumed_cycle = -1;
    for (int q = 0; q < 4; q++) queue_data[q] = 64'hF00D_0000_0000_0000 | 64'(q);
    queue_data[gid] = dat;
    empty    = emp;
    lastElem = lst;
    enable   = 1'b1;
    id       = gid;
    m_ready  = 1'b1;
    step();
    enable = 1'b0;
    vcnt   = 0;
    first  = 1;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) r.pop_seen = pop;
      else        r.pop_stray = r.pop_stray | pop;
      if (m_valid) begin
        vcnt++;
        if (first) begin
          r.data = m_data;
          r.last = m_last;
          first  = 0;
        end else if (m_data !== r.data || m_last !== r.last) begin
          r.unstable = 1;
        end
      end
      if (consumed) begin
        r.pulses++;
        if (r.consumed_cycle < 0) r.consumed_cycle = c;
      end
      if (!busy) begin
        r.finished = 1;
        break;
      end
      m_ready = m_valid ? (vcnt > rdelay) : 1'b1;
      step();
    end
    r.valid_cycles = vcnt;
  endtask

  vec_t vecs[6];
  res_t r;

  initial begin
    reset = 1'b1; enable = 1'b0; id = '0; empty = '1; lastElem = '0;
    queue_data = '0; m_ready = 1'b0;

    // ---- reset state ----
    #2 reset = 1'b0;
    #1;
    chk("rst_pop", 64'(pop), 64'h0);
    chk("rst_m_valid", 64'(m_valid), 64'h0);
    chk("rst_m_data", m_data, 64'h0);
    chk("rst_m_last", 64'(m_last), 64'h0);
    chk("rst_consumed", 64'(consumed), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_overrun", 64'(overrun), 64'h0);
    chk("rst_fwd", 64'(forwarded_count), 64'h0);
    chk("rst_drop", 64'(dropped_count), 64'h0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;

    // ---- table-driven single grants ----
    vecs[0] = '{2'd2, 4'b0000, 4'b0100, 64'hA5A5,                 0, 4'b0100, 1, 1'b1, 3, 1, 0};
    vecs[1] = '{2'd0, 4'b0000, 4'b1110, 64'h1234_5678_9ABC_DEF0,  5, 4'b0001, 6, 1'b0, 8, 1, 0};
    vecs[2] = '{2'd1, 4'b0010, 4'b0000, 64'h55,                   0, 4'b0000, 0, 1'b0, 2, 0, 1};
    vecs[3] = '{2'd3, 4'b0111, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF,  2, 4'b1000, 3, 1'b1, 5, 1, 0};
    vecs[4] = '{2'd1, 4'b1101, 4'b0000, 64'h0BAD_CAFE,            0, 4'b0010, 1, 1'b0, 3, 1, 0};
    vecs[5] = '{2'd0, 4'b1111, 4'b1111, 64'h77,                   0, 4'b0000, 0, 1'b0, 2, 0, 1};

    for (int v = 0; v < 6; v++) begin
      do_grant(vecs[v].gid, vecs[v].emp, vecs[v].lst, vecs[v].dat, vecs[v].rdelay, r);
      exp_fwd  += vecs[v].exp_fwd;
      exp_drop += vecs[v].exp_drop;
      chk($sformatf("vec%0d_finished", v), 64'(r.finished), 64'h1);
      chk($sformatf("vec%0d_pop", v), 64'(r.pop_seen), 64'(vecs[v].exp_pop));
      chk($sformatf("vec%0d_pop_stray", v), 64'(r.pop_stray), 64'h0);
      chk($sformatf("vec%0d_valid_cycles", v), 64'(r.valid_cycles), 64'(vecs[v].exp_valid));
      if (vecs[v].exp_valid > 0) begin
        chk($sformatf("vec%0d_m_data", v), r.data, vecs[v].dat);
        chk($sformatf("vec%0d_m_last", v), 64'(r.last), 64'(vecs[v].exp_last));
        chk($sformatf("vec%0d_stable", v), 64'(r.unstable), 64'h0);
      end
      chk($sformatf("vec%0d_consumed_cycle", v), 64'(r.consumed_cycle), 64'(vecs[v].exp_cons));
      chk($sformatf("vec%0d_pulses", v), 64'(r.pulses), 64'h1);
      chk($sformatf("vec%0d_fwd", v), 64'(forwarded_count), 64'(exp_fwd));
      chk($sformatf("vec%0d_drop", v), 64'(dropped_count), 64'(exp_drop));
    end
    chk("table_overrun", 64'(overrun), 64'h0);

    // ---- overrun: second grant during SEND ----
    begin
      int pulses;
      logic [3:0] pop_acc;
      for (int q = 0; q < 4; q++) queue_data[q] = 64'h3333_0000 | 64'(q);
      queue_data[0] = 64'hDEAD_BEEF_0000_0001;
      empty = 4'b0000; lastElem = 4'b0001;
      enable = 1'b1; id = 2'd0; m_ready = 1'b0;
      step();                                // POP
      pop_acc = pop;
      enable = 1'b0;
      step();                                // SEND
      chk("ovr_m_valid", 64'(m_valid), 64'h1);
      enable = 1'b1; id = 2'd3;
      step();                                // still SEND
      enable = 1'b0;
      chk("ovr_flag", 64'(overrun), 64'h1);
      chk("ovr_m_data", m_data, 64'hDEAD_BEEF_0000_0001);
      m_ready = 1'b1;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
        step();
        pop_acc = pop_acc | pop;
        if (consumed) pulses++;
      end
      exp_fwd++;
      chk("ovr_pulses", 64'(pulses), 64'h1);
      chk("ovr_pop", 64'(pop_acc), 64'h1);
      chk("ovr_fwd", 64'(forwarded_count), 64'(exp_fwd));
      chk("ovr_sticky", 64'(overrun), 64'h1);
    end

    // ---- reset mid-SEND ----
    begin
      int pulses;
      queue_data[2] = 64'h2222; empty = 4'b0000;
      enable = 1'b1; id = 2'd2; m_ready = 1'b0;
      step();                                // POP
      enable = 1'b0;
      step();                                // SEND
      chk("rsend_m_valid_before", 64'(m_valid), 64'h1);
      #2 reset = 1'b0;
      #1;
      chk("rsend_m_valid", 64'(m_valid), 64'h0);
      chk("rsend_busy", 64'(busy), 64'h0);
      chk("rsend_pop", 64'(pop), 64'h0);
      chk("rsend_fwd", 64'(forwarded_count), 64'h0);
      chk("rsend_drop", 64'(dropped_count), 64'h0);
      chk("rsend_overrun", 64'(overrun), 64'h0);
      m_ready = 1'b1;
      @(posedge clock); #1;
      reset = 1'b1;
      exp_fwd = 0; exp_drop = 0; exp_ovr = 0;
      pulses = 0;
      for (int c = 0; c < 3; c++) begin
        if (consumed || pop != 4'b0) pulses++;
        step();
      end
      chk("rsend_no_consumed", 64'(pulses), 64'h0);
      do_grant(2'd2, 4'b0000, 4'b0000, 64'h4242, 0, r);
      exp_fwd++;
      chk("rsend_next_pop", 64'(r.pop_seen), 64'b0100);
      chk("rsend_next_data", r.data, 64'h4242);
      chk("rsend_next_cons", 64'(r.consumed_cycle), 64'h3);
      chk("rsend_next_fwd", 64'(forwarded_count), 64'(exp_fwd));
    end

    // ---- back-to-back round robin ----
    for (int i = 0; i < 10; i++) begin
      logic [1:0] g;
      g = 2'(i % 4);
      do_grant(g, 4'b0000, 4'b0000, 64'h1000 + 64'(i), 0, r);
      exp_fwd++;
      chk($sformatf("b2b%0d_pop", i), 64'(r.pop_seen), 64'(4'b0001 << g));
      chk($sformatf("b2b%0d_data", i), r.data, 64'h1000 + 64'(i));
      chk($sformatf("b2b%0d_pulses", i), 64'(r.pulses), 64'h1);
      chk($sformatf("b2b%0d_cons_low_after", i), 64'(consumed), 64'h0);
    end
    chk("b2b_fwd", 64'(forwarded_count), 64'(exp_fwd));

    // ---- randomized transactions against a transaction-level model ----
    for (int n = 0; n < 150; n++) begin
      int          gid;
      bit          e_empty;
      logic [63:0] e_data;
      logic        e_last;
      bit          sent;
      gid = $urandom_range(0, 3);
      for (int q = 0; q < 4; q++) queue_data[q] = {$urandom, $urandom};
      empty    = 4'($urandom);
      lastElem = 4'($urandom);
      e_empty  = empty[gid];
      e_data   = queue_data[gid];
      e_last   = lastElem[gid];
      enable   = 1'b1;
      id       = 2'(gid);
      m_ready  = 1'($urandom);
      step();                                // POP
      chk("rnd_pop", 64'(pop), e_empty ? 64'h0 : 64'(4'b0001 << gid));
      chk("rnd_pop_valid", 64'(m_valid), 64'h0);
      enable = ($urandom_range(0, 7) == 0);
      id = 2'($urandom);
      if (enable) exp_ovr = 1;
      m_ready = 1'($urandom);
      step();
      if (!e_empty) begin
        sent = 0;
        for (int k = 0; k < 40 && !sent; k++) begin
          chk("rnd_m_valid", 64'(m_valid), 64'h1);
          chk("rnd_m_data", m_data, e_data);
          chk("rnd_m_last", 64'(m_last), 64'(e_last));
          chk("rnd_send_pop", 64'(pop), 64'h0);
          for (int q = 0; q < 4; q++) queue_data[q] = {$urandom, $urandom};
          empty   = 4'($urandom);
          m_ready = (k >= 20) ? 1'b1 : 1'($urandom);
          sent    = m_ready;
          enable  = ($urandom_range(0, 7) == 0);
          id      = 2'($urandom);
          if (enable) exp_ovr = 1;
          step();
        end
        exp_fwd++;
      end else begin
        exp_drop++;
      end
      chk("rnd_consumed", 64'(consumed), 64'h1);
      chk("rnd_done_valid", 64'(m_valid), 64'h0);
      enable = ($urandom_range(0, 7) == 0);
      id     = 2'($urandom);
      if (enable) exp_ovr = 1;
      step();                                // IDLE
      chk("rnd_idle_busy", 64'(busy), 64'h0);
      chk("rnd_idle_consumed", 64'(consumed), 64'h0);
      chk("rnd_fwd", 64'(forwarded_count), 64'(exp_fwd));
      chk("rnd_drop", 64'(dropped_count), 64'(exp_drop));
      chk("rnd_overrun", 64'(overrun), 64'(exp_ovr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
